pc_fetch_ctrl: RTL

- Program-counter register and fetch controller for the BIP-style core.
- Holds the current instruction address and drives it to program memory and to the incrementer.
- Loads the incrementer's result back as the next address.
- Runs a small run/halt state machine with stall and single-step (debug) control, and counts retired instructions.

---
 rtl/pc_fetch_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch controller for the BIP-style core.
// Holds the current instruction address, loads the incrementer result on
// each advance, runs an IDLE/RUN/HALT machine with stall and single-step
// control, and keeps a saturating count of retired instructions.
module pc_fetch_ctrl #(
    parameter int unsigned                  MSB      = 11,
    parameter int unsigned                  OPC_W    = 5,
    parameter logic        [OPC_W-1:0]      HALT_OPC = 5'b00000,
    parameter int unsigned                  CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stall,
    input  logic             i_step_mode,
    input  logic             i_step,
    input  logic [OPC_W-1:0] i_opcode,
    input  logic [MSB-1:0]   i_inc,
    output logic [MSB-1:0]   o_addr,
    output logic             o_fetch_en,
    output logic             o_running,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_instr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [MSB-1:0]   addr;
    logic [MSB-1:0]   addr_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             adv;
    logic             is_halt;

    // Advance qualifier: stall wins over step; a dropped step is not queued.
    always_comb begin
        adv     = !i_stall && (!i_step_mode || i_step);
        is_halt = (i_opcode == HALT_OPC);
    end

    // Next-state, next-PC and next-count decode.
    always_comb begin
        state_next = state;
        addr_next  = addr;
        count_next = count;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (adv) begin
                    // Counter saturates at all-ones instead of wrapping.
                    if (count != '1) begin
                        count_next = count + CNT_W'(1);
                    end
                    // The halt instruction retires but the PC keeps pointing at it.
                    if (is_halt) begin
                        state_next = HALT;
                    end else begin
                        addr_next = i_inc;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, PC and counter registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            addr  <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            addr  <= addr_next;
            count <= count_next;
        end
    end

    // Moore status outputs decoded from the state register only.
    always_comb begin
        o_fetch_en    = (state == RUN);
        o_running     = (state == RUN);
        o_halted      = (state == HALT);
        o_addr        = addr;
        o_instr_count = count;
    end

endmodule
